lcd_spi_tx: RTL and testbench

Byte-level SPI mode-0 transmitter for the ST7789-class LCD link, sitting directly downstream of the LCD command/pixel sequencer. Accepts one byte plus its D/C flag per valid/ready handshake. Serialises the byte MSB-first on `scl`/`sda`. Manages `cs` across multi-byte frames, so the sequencer only pushes bytes and marks the last one.

---
 rtl/lcd_pkg.sv | 22 ++
 rtl/lcd_spi_tx_half_tick.sv | 39 +++
 rtl/lcd_spi_tx.sv | 139 +++++++++++++
 tb/tb_lcd_spi_tx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD link: transmitter state encoding, ST7789 command
// bytes and RGB565 colour constants used by the sequencer and the SPI transmitter.
package lcd_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LOW   = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  localparam logic [7:0] SLPOUT        = 8'h11;
  localparam logic [7:0] DISPON        = 8'h29;
  localparam logic [7:0] COLMOD        = 8'h3A;
  localparam logic [7:0] COLMOD_RGB565 = 8'h55;
  localparam logic [7:0] RAMWR         = 8'h2C;

  localparam logic [15:0] RED   = 16'hF800;
  localparam logic [15:0] GREEN = 16'h07E0;
  localparam logic [15:0] BLUE  = 16'h001F;

endpackage

// File: rtl/lcd_spi_tx_half_tick.sv
// Half-period counter: counts 0..CLK_DIV-1 and flags the last cycle of each phase.
// tick_next predicts whether the coming cycle will be a tick cycle.
module spi_half_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick,
  output logic tick_next
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Every phase change coincides with a tick, so reloading on tick covers it.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  assign tick_next = (cnt_d == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lcd_spi_tx.sv
// Byte-level SPI mode-0 transmitter for the LCD link. Serialises one byte per
// handshake MSB-first and keeps cs low across bytes until the one marked last.
module lcd_spi_tx
  import lcd_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_dc,
  input  logic       in_last,
  output logic       scl,
  output logic       sda,
  output logic       cs,
  output logic       dc,
  output logic       done,
  output logic       busy
);

  logic [2:0] state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       tail_q, tail_d;
  logic       last_q, last_d;
  logic       sda_q, sda_d;
  logic       dc_q, dc_d;
  logic       scl_q, scl_d;
  logic       cs_q, cs_d;
  logic       done_q, done_d;
  logic       restart;
  logic       tick;
  logic       tick_next;

  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_WAIT);
  assign busy     = (state_q != ST_IDLE);
  assign restart  = in_ready;

  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .tick      (tick),
    .tick_next (tick_next)
  );

  // tail marks the LOW phase after the 8th HIGH; sda shifts as scl falls.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tail_d  = tail_q;
    last_d  = last_q;
    sda_d   = sda_q;
    dc_d    = dc_q;
    case (state_q)
      ST_IDLE, ST_WAIT: begin
        if (in_valid) begin
          state_d = ST_SETUP;
          sda_d   = in_data[7];
          shift_d = {in_data[6:0], 1'b0};
          dc_d    = in_dc;
          last_d  = in_last;
          bit_d   = 3'd7;
          tail_d  = 1'b0;
        end
      end
      ST_SETUP: begin
        if (tick) state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (tick) begin
          state_d = ST_LOW;
          sda_d   = shift_q[7];
          shift_d = {shift_q[6:0], 1'b0};
          if (bit_q == 3'd0) begin
            tail_d = 1'b1;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end
      ST_LOW: begin
        if (tick) begin
          if (!tail_q)     state_d = ST_HIGH;
          else if (last_q) state_d = ST_GAP;
          else             state_d = ST_WAIT;
        end
      end
      ST_GAP: begin
        if (tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin values are derived from the next state so they line up with it.
  always_comb begin
    scl_d  = (state_d == ST_HIGH);
    cs_d   = !((state_d == ST_SETUP) || (state_d == ST_HIGH) ||
               (state_d == ST_LOW)   || (state_d == ST_WAIT));
    done_d = (state_d == ST_LOW) && tail_d && tick_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      bit_q   <= 3'd7;
      shift_q <= 8'h00;
      tail_q  <= 1'b0;
      last_q  <= 1'b0;
      sda_q   <= 1'b0;
      dc_q    <= 1'b0;
      scl_q   <= 1'b0;
      cs_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tail_q  <= tail_d;
      last_q  <= last_d;
      sda_q   <= sda_d;
      dc_q    <= dc_d;
      scl_q   <= scl_d;
      cs_q    <= cs_d;
      done_q  <= done_d;
    end
  end

  assign scl  = scl_q;
  assign sda  = sda_q;
  assign cs   = cs_q;
  assign dc   = dc_q;
  assign done = done_q;

endmodule

// File: tb/tb_lcd_spi_tx.sv
// Directed bench for lcd_spi_tx: one instance at CLK_DIV=2 and one at CLK_DIV=1,
// checked against hand-computed cycle positions, sampled bits and pulse counts.
module tb_lcd_spi_tx;
  import lcd_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid1, in_valid2;
  logic [7:0] in_data;
  logic       in_dc, in_last;
  logic       in_ready1, scl1, sda1, cs1, dc1, done1, busy1;
  logic       in_ready2, scl2, sda2, cs2, dc2, done2, busy2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  lcd_spi_tx #(.CLK_DIV(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data), .in_dc(in_dc), .in_last(in_last),
    .scl(scl2), .sda(sda2), .cs(cs2), .dc(dc2), .done(done2), .busy(busy2)
  );

  lcd_spi_tx #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data), .in_dc(in_dc), .in_last(in_last),
    .scl(scl1), .sda(sda1), .cs(cs1), .dc(dc1), .done(done1), .busy(busy1)
  );

  always #5 clk = ~clk;

  // cyc names the current clock cycle; it advances at each rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records SCL rises with the bit seen on sda, done pulses and cs edges.
  int          riseCnt2 = 0, riseCnt1 = 0;
  int          rc2 [64];
  int          rc1 [64];
  logic [31:0] riseBits2 = '0, riseBits1 = '0;
  int          doneCnt2 = 0, doneCnt1 = 0, lastDone2 = -1;
  int          csFall2 = 0, csRise2 = 0, lastCsFall2 = -1, lastCsRise2 = -1;
  int          viol2 = 0, viol1 = 0;
  logic        sclPrev2 = 0, sdaPrev2 = 0, csPrev2 = 1, sclPrev1 = 0, sdaPrev1 = 0;

  always @(negedge clk) begin
    if (scl2 && !sclPrev2) begin
      rc2[riseCnt2 & 63] = cyc;
      riseBits2 = {riseBits2[30:0], sda2};
      riseCnt2++;
    end
    if (scl1 && !sclPrev1) begin
      rc1[riseCnt1 & 63] = cyc;
      riseBits1 = {riseBits1[30:0], sda1};
      riseCnt1++;
    end
    if ((sda2 !== sdaPrev2) && scl2) viol2++;
    if ((sda1 !== sdaPrev1) && scl1) viol1++;
    if (done2) begin doneCnt2++; lastDone2 = cyc; end
    if (done1) doneCnt1++;
    if (!cs2 && csPrev2) begin csFall2++; lastCsFall2 = cyc; end
    if (cs2 && !csPrev2) begin csRise2++; lastCsRise2 = cyc; end
    sclPrev2 = scl2; sdaPrev2 = sda2; csPrev2 = cs2;
    sclPrev1 = scl1; sdaPrev1 = sda1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitNeg();
    @(negedge clk);
    #1;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) waitNeg();
  endtask

  task automatic waitReady(input bit useD1, output int acc);
    int n;
    n = 0;
    while (((useD1 ? in_ready1 : in_ready2) !== 1'b1) && (n < 200)) begin
      waitNeg();
      n++;
    end
    checkOutput("ready_wait_bound", (n < 200), 1);
    acc = cyc;
  endtask

  // Offer one byte, wait for the accepting edge, then withdraw in_valid.
  task automatic applyStimulus(input bit useD1, input logic [7:0] d, input logic dcv,
                               input logic lastv, output int acc);
    in_data = d; in_dc = dcv; in_last = lastv;
    if (useD1) in_valid1 = 1'b1; else in_valid2 = 1'b1;
    waitReady(useD1, acc);
    waitNeg();
    in_valid1 = 1'b0;
    in_valid2 = 1'b0;
  endtask

  initial begin
    int acc, acc2, r0, r1, d0, f0, ri0;
    reset = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
    in_data = 8'h00; in_dc = 1'b0; in_last = 1'b0;
    waitNeg(); waitNeg();

    checkOutput("rst_cs", cs2, 1);
    checkOutput("rst_scl", scl2, 0);
    checkOutput("rst_sda", sda2, 0);
    checkOutput("rst_dc", dc2, 0);
    checkOutput("rst_done", done2, 0);
    checkOutput("rst_busy", busy2, 0);
    reset = 1'b1;
    waitNeg();
    checkOutput("rst_ready", in_ready2, 1);

    $display("[TB] single command byte, D=2");
    r0 = riseCnt2; d0 = doneCnt2;
    applyStimulus(0, SLPOUT, 1'b0, 1'b1, acc);
    checkOutput("t1_cs_low", cs2, 0);
    checkOutput("t1_sda_bit7", sda2, 0);
    checkOutput("t1_dc", dc2, 0);
    checkOutput("t1_ready_low", in_ready2, 0);
    checkOutput("t1_busy", busy2, 1);
    waitUntil(acc + 36);
    checkOutput("t1_ready_gap", in_ready2, 0);
    checkOutput("t1_cs_gap", cs2, 1);
    waitUntil(acc + 37);
    checkOutput("t1_ready_idle", in_ready2, 1);
    checkOutput("t1_rises", riseCnt2 - r0, 8);
    checkOutput("t1_bits", riseBits2[7:0], 8'h11);
    checkOutput("t1_first_rise", rc2[r0 & 63], acc + 3);
    checkOutput("t1_last_rise", rc2[(r0 + 7) & 63], acc + 31);
    checkOutput("t1_done_cnt", doneCnt2 - d0, 1);
    checkOutput("t1_done_cyc", lastDone2, acc + 34);
    checkOutput("t1_cs_fall", lastCsFall2, acc + 1);
    checkOutput("t1_cs_rise", lastCsRise2, acc + 35);

    $display("[TB] two-byte frame with in_valid held, D=2");
    r0 = riseCnt2; d0 = doneCnt2; f0 = csFall2; ri0 = csRise2;
    in_data = COLMOD; in_dc = 1'b0; in_last = 1'b0; in_valid2 = 1'b1;
    waitReady(0, acc);
    waitNeg();
    in_data = COLMOD_RGB565; in_dc = 1'b1; in_last = 1'b1;
    checkOutput("t2_dc_first", dc2, 0);
    checkOutput("t2_sda_first", sda2, 0);
    waitUntil(acc + 34);
    checkOutput("t2_done_no_ready", in_ready2, 0);
    checkOutput("t2_done", done2, 1);
    waitUntil(acc + 35);
    checkOutput("t2_wait_ready", in_ready2, 1);
    checkOutput("t2_dc_hold", dc2, 0);
    checkOutput("t2_cs_wait", cs2, 0);
    waitNeg();
    in_valid2 = 1'b0;
    checkOutput("t2_dc_second", dc2, 1);
    checkOutput("t2_cs_second", cs2, 0);
    waitUntil(acc + 72);
    checkOutput("t2_rises", riseCnt2 - r0, 16);
    checkOutput("t2_bits", riseBits2[15:0], 16'h3A55);
    checkOutput("t2_done_cnt", doneCnt2 - d0, 2);
    checkOutput("t2_cs_falls", csFall2 - f0, 1);
    checkOutput("t2_cs_rises", csRise2 - ri0, 1);
    checkOutput("t2_cs_rise_cyc", lastCsRise2, acc + 70);

    $display("[TB] idle WAIT for 50 cycles, D=2");
    r0 = riseCnt2; d0 = doneCnt2; ri0 = csRise2;
    applyStimulus(0, 8'hA5, 1'b1, 1'b0, acc);
    waitUntil(acc + 35);
    checkOutput("t3_wait_ready", in_ready2, 1);
    checkOutput("t3_wait_busy", busy2, 1);
    r1 = riseCnt2;
    waitUntil(acc + 85);
    checkOutput("t3_no_edges", riseCnt2 - r1, 0);
    checkOutput("t3_cs_held", cs2, 0);
    checkOutput("t3_scl_low", scl2, 0);
    checkOutput("t3_no_cs_rise", csRise2 - ri0, 0);
    checkOutput("t3_one_done", doneCnt2 - d0, 1);
    applyStimulus(0, 8'h5A, 1'b1, 1'b1, acc2);
    checkOutput("t3_accept_cyc", acc2, acc + 85);
    waitUntil(acc2 + 37);
    checkOutput("t3_rises", riseCnt2 - r0, 16);
    checkOutput("t3_bits", riseBits2[15:0], 16'hA55A);
    checkOutput("t3_done_cnt", doneCnt2 - d0, 2);

    $display("[TB] reset in the middle of a byte, D=2");
    d0 = doneCnt2;
    applyStimulus(0, 8'hC3, 1'b1, 1'b1, acc);
    waitUntil(acc + 10);
    reset = 1'b0;
    #1;
    checkOutput("t4_cs_async", cs2, 1);
    checkOutput("t4_scl_async", scl2, 0);
    checkOutput("t4_busy_async", busy2, 0);
    checkOutput("t4_dc_async", dc2, 0);
    waitNeg(); waitNeg();
    reset = 1'b1;
    waitNeg();
    checkOutput("t4_no_done", doneCnt2 - d0, 0);
    r0 = riseCnt2; d0 = doneCnt2;
    applyStimulus(0, 8'h96, 1'b0, 1'b1, acc2);
    checkOutput("t4_sda_bit7", sda2, 1);
    waitUntil(acc2 + 37);
    checkOutput("t4_rises", riseCnt2 - r0, 8);
    checkOutput("t4_bits", riseBits2[7:0], 8'h96);
    checkOutput("t4_done_cnt", doneCnt2 - d0, 1);
    checkOutput("t4_ready", in_ready2, 1);

    $display("[TB] RGB565 pixel, D=1");
    r0 = riseCnt1; d0 = doneCnt1;
    applyStimulus(1, RED[15:8], 1'b1, 1'b0, acc);
    applyStimulus(1, RED[7:0], 1'b1, 1'b1, acc2);
    checkOutput("t5_b2b_period", acc2 - acc, 18);
    waitUntil(acc2 + 18);
    checkOutput("t5_gap_ready", in_ready1, 0);
    checkOutput("t5_gap_cs", cs1, 1);
    waitUntil(acc2 + 19);
    checkOutput("t5_idle_ready", in_ready1, 1);
    checkOutput("t5_rises", riseCnt1 - r0, 16);
    checkOutput("t5_bits", riseBits1[15:0], 16'hF800);
    checkOutput("t5_first_rise", rc1[r0 & 63], acc + 2);
    checkOutput("t5_eighth_rise", rc1[(r0 + 7) & 63], acc + 16);
    checkOutput("t5_second_rise", rc1[(r0 + 1) & 63], acc + 4);
    checkOutput("t5_ninth_rise", rc1[(r0 + 8) & 63], acc2 + 2);
    checkOutput("t5_done_cnt", doneCnt1 - d0, 2);

    checkOutput("sda_stable_d2", viol2, 0);
    checkOutput("sda_stable_d1", viol1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
